// File: rtl/decoder_scan_if.sv
// Bus bundle for the scanning decoder: control inputs from the controller,
// registered select/index/wrap outputs back from the decoder.
interface decoder_scan_if #(
    parameter int N       = 3,
    parameter int DWELL_W = 8
);
    logic               E;
    logic               mode;
    logic [N-1:0]       A;
    logic [DWELL_W-1:0] dwell;
    logic [2**N-1:0]    S;
    logic [N-1:0]       idx;
    logic               wrap;

    modport master (
        output E, mode, A, dwell,
        input  S, idx, wrap
    );

    modport slave (
        input  E, mode, A, dwell,
        output S, idx, wrap
    );
endinterface

// File: rtl/decoder_scan.sv
// Registered N-to-2^N select decoder with a DIRECT mode (decode A) and a SCAN
// mode that steps through outputs 0..M-1, holding each for dwell+1 cycles.
module decoder_scan #(
    parameter int N          = 3,
    parameter int M          = 8,
    parameter int DWELL_W    = 8,
    parameter int ACTIVE_LOW = 0
) (
    input  logic          clk,
    input  logic          rst,
    decoder_scan_if.slave bus
);
    localparam int          SW       = 2**N;
    localparam logic [N-1:0] LAST_IDX = N'(M - 1);

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [N-1:0]       idx_r;
    logic [N-1:0]       idx_nxt_s;
    logic [DWELL_W-1:0] cnt_r;
    logic [DWELL_W-1:0] cnt_nxt_s;
    logic [SW-1:0]      sel_r;
    logic [SW-1:0]      sel_nxt_s;
    logic               wrap_r;
    logic               wrap_nxt_s;
    logic               resume_r;
    logic               resume_nxt_s;
    logic               scan_continue_s;

    function automatic logic [SW-1:0] decode_sel(input logic [N-1:0] a, input logic on);
        logic [SW-1:0] v;
        v = {SW{1'b0}};
        if (on) begin
            v[a] = 1'b1;
        end else begin
            v = {SW{1'b0}};
        end
        if (ACTIVE_LOW != 0) begin
            v = ~v;
        end else begin
            v = v;
        end
        return v;
    endfunction

    // Next-state and next-output evaluation; actions follow the state being entered.
    always_comb begin
        state_nxt_s     = state_r;
        idx_nxt_s       = idx_r;
        cnt_nxt_s       = cnt_r;
        sel_nxt_s       = sel_r;
        wrap_nxt_s      = 1'b0;
        resume_nxt_s    = resume_r;
        scan_continue_s = 1'b0;

        if (!bus.E) begin
            state_nxt_s = ST_OFF;
        end else if (!bus.mode) begin
            state_nxt_s = ST_DIRECT;
        end else begin
            state_nxt_s = ST_SCAN;
        end

        // A scan continues if it was running, or was paused by E and never left SCAN.
        scan_continue_s = (state_r == ST_SCAN) || ((state_r == ST_OFF) && resume_r);

        case (state_nxt_s)
            ST_OFF: begin
                sel_nxt_s  = decode_sel({N{1'b0}}, 1'b0);
                wrap_nxt_s = 1'b0;
            end
            ST_DIRECT: begin
                idx_nxt_s    = bus.A;
                cnt_nxt_s    = {DWELL_W{1'b0}};
                sel_nxt_s    = decode_sel(bus.A, 1'b1);
                wrap_nxt_s   = 1'b0;
                resume_nxt_s = 1'b0;
            end
            ST_SCAN: begin
                if (!scan_continue_s) begin
                    idx_nxt_s  = {N{1'b0}};
                    cnt_nxt_s  = {DWELL_W{1'b0}};
                    wrap_nxt_s = 1'b0;
                end else if (cnt_r >= bus.dwell) begin
                    cnt_nxt_s = {DWELL_W{1'b0}};
                    if (idx_r == LAST_IDX) begin
                        idx_nxt_s  = {N{1'b0}};
                        wrap_nxt_s = 1'b1;
                    end else begin
                        idx_nxt_s  = idx_r + N'(1);
                        wrap_nxt_s = 1'b0;
                    end
                end else begin
                    cnt_nxt_s  = cnt_r + DWELL_W'(1);
                    wrap_nxt_s = 1'b0;
                end
                sel_nxt_s    = decode_sel(idx_nxt_s, 1'b1);
                resume_nxt_s = 1'b1;
            end
            default: begin
                idx_nxt_s    = {N{1'b0}};
                cnt_nxt_s    = {DWELL_W{1'b0}};
                sel_nxt_s    = decode_sel({N{1'b0}}, 1'b0);
                wrap_nxt_s   = 1'b0;
                resume_nxt_s = 1'b0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_OFF;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_r    <= {N{1'b0}};
            cnt_r    <= {DWELL_W{1'b0}};
            sel_r    <= decode_sel({N{1'b0}}, 1'b0);
            wrap_r   <= 1'b0;
            resume_r <= 1'b0;
        end else begin
            idx_r    <= idx_nxt_s;
            cnt_r    <= cnt_nxt_s;
            sel_r    <= sel_nxt_s;
            wrap_r   <= wrap_nxt_s;
            resume_r <= resume_nxt_s;
        end
    end

    assign bus.S    = sel_r;
    assign bus.idx  = idx_r;
    assign bus.wrap = wrap_r;
endmodule
